alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, two-stage pipelined ALU with an internal register file, valid/ready handshakes on the issue and result sides, a program-counter accumulator and a status-flag output. It generalises the datapath's 20-bit, 16-register ALU:
- configurable data width and register count;
- a wider operation set;
- read-after-write hazard handling;
- output backpressure.

It sits between instruction decode (issue side) and the result/commit logic (result side).

## Interface
- DATA_W, 20: operand, result and pc width
- NUM_REGS, 16: register-file depth, ≥2
- RSEL_W, $clog2(NUM_REGS): register-select width (derived)

One clock `clk`; reset `rst_n` is asynchronous and active-low.

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  issue request
- in_ready  out  1  issue accepted when in_valid && in_ready
- opcode  in  5  operation
- src1_sel, src2_sel, dst_sel  in  RSEL_W  read and write register indices
- src1_imm, src2_imm  in  DATA_W  immediates
- imm1_en, imm2_en  in  1  replace register operand A/B with its immediate
- wb_en  in  1  write result to regfile[dst_sel]
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid && out_ready
- dst  out  DATA_W  result
- dst_sel_out  out  RSEL_W  destination index of the result
- flags  out  4  {C,V,N,Z} of the result
- illegal  out  1  result came from an undefined opcode
- pc_out  out  DATA_W  pc accumulator

## Operation
- Operands: A = imm1_en ? src1_imm : regfile[src1_sel]; B = imm2_en ? src2_imm : regfile[src2_sel].
- Opcodes:
  - 0x00 ADD A+B
  - 0x01 SUB A−B
  - 0x02 AND
  - 0x03 OR
  - 0x04 XOR
  - 0x05 SLL A<<B
  - 0x06 SRL
  - 0x07 SRA
  - 0x08 SLT (signed, result 1 or 0)
  - 0x09 PCADD: pc ← pc+B, result = new pc
  - 0x0A MOV: result = B
- Shifts: if B ≥ DATA_W, SLL/SRL give 0 and SRA gives all sign bits.
- Arithmetic wraps modulo 2^DATA_W.
- Flags:
  - C = carry out (ADD) or borrow (SUB), else 0
  - V = signed overflow (ADD/SUB), else 0
  - N = result MSB
  - Z = result==0
- Any other opcode: result 0, flags 0, illegal=1, no regfile write, pc unchanged.
- Stage S1, on accept: operands, opcode, dst_sel and wb_en are captured; S1 valid is set.
- Stage S2 (output register), when S1 valid and the output register is empty or being consumed:
  - the S1 result moves to dst/flags/illegal and out_valid=1;
  - on the same edge, regfile[dst_sel] is written if wb_en && !illegal, and pc is updated for PCADD.
- in_ready = !S1valid || S1 advances this cycle, and no hazard stall is active.
- RAW hazard: S1 valid with wb_en, S1 dst equal to an incoming register-sourced src, and no forwarding. See Configuration for how it is resolved.
- Output backpressure: out_valid && !out_ready holds dst/flags/illegal stable, S1 stalls, then in_ready drops.
- Reset values: in_ready 1; out_valid 0; dst 0; dst_sel_out 0; flags 0; illegal 0; pc_out 0; all registers 0; S1 invalid.
- Reset mid-operation discards S1 and the output register; nothing is written back.

## Timing
- Accept at edge E0 → result visible, out_valid=1, after E1; regfile and pc written at E1.
- Throughput: one op per cycle when out_ready=1 and there is no unforwarded hazard.
- Regfile read is combinational at issue. A write and a read of the same index in one cycle return the old value, unless forwarded.
- A PCADD accepted back-to-back uses the pc value updated by the previous PCADD.

## Configuration
- ALU_FWD_EN defined: the S1 result is bypassed combinationally into the A/B operand on a RAW hazard, with no stall.
- ALU_FWD_EN undefined: in_ready is held 0 while the hazard exists, for one cycle when out_ready=1, until S1 writes back.
- Results are identical in both modes; only the cycle counts differ.

## Structure
- Package alu_pipe_pkg holds:
  - the opcode localparams/enum;
  - the flag bit indices (C=3, V=2, N=1, Z=0);
  - a typedef for the S1 pipeline record.
- Sub-module alu_regfile: NUM_REGS×DATA_W, two combinational read ports, one synchronous write port, asynchronous clear.

## Test plan
- Reset: after reset, all outputs match their reset values, and MOV r1←imm 0x12345 then ADD r2=r1+r1 gives dst=0x2468A with flags Z=0, N=0.
- Arithmetic flags: ADD 0xFFFFF+1 gives dst 0, C=1, Z=1; SUB 0x7FFFF−0xFFFFF gives 0x80000, V=1, N=1.
- Back-to-back hazard: MOV r3←5, then ADD r4=r3+r3 the next cycle gives 10. Cycle count: 2 accepts in 2 cycles with ALU_FWD_EN, 3 cycles without.
- Backpressure: hold out_ready=0 for 4 cycles with 3 ops issued; dst stays stable, in_ready drops after the 2nd accept, and all 3 results emerge in order once out_ready=1.
- PC and shifts: PCADD B=0x10 twice gives pc_out 0x20. SRA 0x80000 by 25 gives 0xFFFFF; SLL 1 by 19 gives 0x80000.
- Illegal op: opcode 0x1F with wb_en=1 gives illegal=1, dst 0, and the destination register keeps its prior value.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the two-stage pipelined ALU.
// No logic; constants, flag bit positions and the S1 control record.
// Not applicable (package only).
//
// Contents:
//   OP_*        5-bit opcode encodings
//   FLG_*       bit positions inside the 4-bit {C,V,N,Z} flag vector
//   s1_ctrl_t   width-independent control part of the S1 pipeline record
//   op_legal()  opcode decode check
package alu_pipe_pkg;

    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_SUB   = 5'h01;
    localparam logic [4:0] OP_AND   = 5'h02;
    localparam logic [4:0] OP_OR    = 5'h03;
    localparam logic [4:0] OP_XOR   = 5'h04;
    localparam logic [4:0] OP_SLL   = 5'h05;
    localparam logic [4:0] OP_SRL   = 5'h06;
    localparam logic [4:0] OP_SRA   = 5'h07;
    localparam logic [4:0] OP_SLT   = 5'h08;
    localparam logic [4:0] OP_PCADD = 5'h09;
    localparam logic [4:0] OP_MOV   = 5'h0A;

    localparam int FLG_C = 3;
    localparam int FLG_V = 2;
    localparam int FLG_N = 1;
    localparam int FLG_Z = 0;

    // Control half of the S1 record. The operand and destination fields
    // depend on module parameters and therefore live next to it in the top.
    // legal is decoded once at capture so S2 does not re-decode the opcode.
    typedef struct packed {
        logic [4:0] opcode;
        logic       wb_en;
        logic       legal;
    } s1_ctrl_t;

    function automatic logic op_legal(input logic [4:0] op);
        return (op <= OP_MOV);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: NUM_REGS x DATA_W, two read ports, one write port.
// Reads are combinational; writes land on the rising edge of clk.
// No backpressure; the write enable is qualified by the caller.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low clear of all entries
//   rd0_addr / rd0_dat    read port 0 (index, data)
//   rd1_addr / rd1_dat    read port 1 (index, data)
//   wr_en, wr_addr, wr_dat  synchronous write port
// A same-cycle read and write of one index returns the old contents.
module alu_regfile #(
    parameter int DATA_W   = 20,
    parameter int NUM_REGS = 16,
    parameter int RSEL_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RSEL_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_dat,
    input  logic [RSEL_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_dat,
    input  logic              wr_en,
    input  logic [RSEL_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Decoded reads so that indices beyond NUM_REGS-1 read as zero when
    // NUM_REGS is not a power of two.
    always_comb begin
        rd0_dat = '0;
        rd1_dat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd0_addr == RSEL_W'(i)) rd0_dat = mem[i];
            if (rd1_addr == RSEL_W'(i)) rd1_dat = mem[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && wr_addr == RSEL_W'(i)) mem[i] <= wr_dat;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with register file, pc accumulator and status flags.
// Latency 2 edges: accept at E0, result/out_valid and regfile/pc write at E1.
// Output stall freezes the result, then S1, then in_ready; RAW stalls unless forwarded.
//
// Build option: ALU_FWD_EN - bypass the S1 result into the operands on a
// read-after-write hazard instead of stalling issue for a cycle.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         issue handshake
//   opcode                      5-bit operation
//   src1_sel, src2_sel, dst_sel register indices
//   src1_imm, src2_imm          immediates; imm1_en/imm2_en select them
//   wb_en                       write result to regfile[dst_sel]
//   out_valid / out_ready       result handshake
//   dst, dst_sel_out, flags, illegal  result, its destination, {C,V,N,Z}, bad opcode
//   pc_out                      pc accumulator
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W   = 20,
    parameter int NUM_REGS = 16,
    parameter int RSEL_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        opcode,
    input  logic [RSEL_W-1:0] src1_sel,
    input  logic [RSEL_W-1:0] src2_sel,
    input  logic [RSEL_W-1:0] dst_sel,
    input  logic [DATA_W-1:0] src1_imm,
    input  logic [DATA_W-1:0] src2_imm,
    input  logic              imm1_en,
    input  logic              imm2_en,
    input  logic              wb_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dst,
    output logic [RSEL_W-1:0] dst_sel_out,
    output logic [3:0]        flags,
    output logic              illegal,
    output logic [DATA_W-1:0] pc_out
);

    localparam int                SHW    = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] DW_LIM = DATA_W'(DATA_W);
    localparam int                MSB    = DATA_W - 1;

    // S1 pipeline record
    logic              s1_vld;
    s1_ctrl_t          s1_ctrl;
    logic [RSEL_W-1:0] s1_dst;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;

    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] rd_a_dat;
    logic [DATA_W-1:0] rd_b_dat;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    logic              s1_adv;
    logic              s1_writes;
    logic              hz_a;
    logic              hz_b;
    logic              stall_hz;
    logic              accept;

    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_flags;
    logic              alu_c;
    logic              alu_v;
    logic [DATA_W:0]   sum_w;
    logic [DATA_W:0]   diff_w;
    logic [SHW-1:0]    shamt;
    logic              shift_big;

    // ------------------------------------------------------------------
    // Issue side: operand fetch, hazard detection, handshake
    // ------------------------------------------------------------------
    alu_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .RSEL_W   (RSEL_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd0_addr (src1_sel),
        .rd0_dat  (rd_a_dat),
        .rd1_addr (src2_sel),
        .rd1_dat  (rd_b_dat),
        .wr_en    (s1_adv && s1_writes),
        .wr_addr  (s1_dst),
        .wr_dat   (alu_res)
    );

    // S1 moves on whenever the output register is empty or draining.
    assign s1_adv    = s1_vld && (!out_valid || out_ready);
    // Illegal ops never write back, so they cannot create a hazard.
    assign s1_writes = s1_vld && s1_ctrl.wb_en && s1_ctrl.legal;
    assign hz_a      = s1_writes && !imm1_en && (src1_sel == s1_dst);
    assign hz_b      = s1_writes && !imm2_en && (src2_sel == s1_dst);

`ifdef ALU_FWD_EN
    // Issue only proceeds while S1 advances, so alu_res is exactly the
    // value that lands in the regfile on the accepting edge.
    assign op_a     = imm1_en ? src1_imm : (hz_a ? alu_res : rd_a_dat);
    assign op_b     = imm2_en ? src2_imm : (hz_b ? alu_res : rd_b_dat);
    assign stall_hz = 1'b0;
`else
    assign op_a     = imm1_en ? src1_imm : rd_a_dat;
    assign op_b     = imm2_en ? src2_imm : rd_b_dat;
    assign stall_hz = hz_a || hz_b;
`endif

    assign in_ready = (!s1_vld || s1_adv) && !stall_hz;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_ctrl <= '0;
            s1_dst  <= '0;
            s1_a    <= '0;
            s1_b    <= '0;
        end else if (accept) begin
            s1_vld         <= 1'b1;
            s1_ctrl.opcode <= opcode;
            s1_ctrl.wb_en  <= wb_en;
            s1_ctrl.legal  <= op_legal(opcode);
            s1_dst         <= dst_sel;
            s1_a           <= op_a;
            s1_b           <= op_b;
        end else if (s1_adv) begin
            s1_vld <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // S1 execute (combinational from the S1 record and pc)
    // ------------------------------------------------------------------
    assign sum_w     = {1'b0, s1_a} + {1'b0, s1_b};
    assign diff_w    = {1'b0, s1_a} - {1'b0, s1_b};
    assign shamt     = s1_b[SHW-1:0];
    assign shift_big = (s1_b >= DW_LIM);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (s1_ctrl.opcode)
            OP_ADD: begin
                alu_res = sum_w[MSB:0];
                alu_c   = sum_w[DATA_W];
                alu_v   = (s1_a[MSB] == s1_b[MSB]) && (sum_w[MSB] != s1_a[MSB]);
            end
            OP_SUB: begin
                alu_res = diff_w[MSB:0];
                alu_c   = diff_w[DATA_W];   // borrow
                alu_v   = (s1_a[MSB] != s1_b[MSB]) && (diff_w[MSB] != s1_a[MSB]);
            end
            OP_AND:   alu_res = s1_a & s1_b;
            OP_OR:    alu_res = s1_a | s1_b;
            OP_XOR:   alu_res = s1_a ^ s1_b;
            OP_SLL:   alu_res = shift_big ? '0 : (s1_a << shamt);
            OP_SRL:   alu_res = shift_big ? '0 : (s1_a >> shamt);
            OP_SRA:   alu_res = shift_big ? {DATA_W{s1_a[MSB]}}
                                          : $unsigned($signed(s1_a) >>> shamt);
            OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            OP_PCADD: alu_res = pc_q + s1_b;
            OP_MOV:   alu_res = s1_b;
            default:  alu_res = '0;
        endcase
    end

    // Illegal ops report all-zero flags, including Z.
    always_comb begin
        alu_flags = '0;
        if (s1_ctrl.legal) begin
            alu_flags[FLG_C] = alu_c;
            alu_flags[FLG_V] = alu_v;
            alu_flags[FLG_N] = alu_res[MSB];
            alu_flags[FLG_Z] = (alu_res == '0);
        end
    end

    // ------------------------------------------------------------------
    // S2 output register and pc accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            dst         <= '0;
            dst_sel_out <= '0;
            flags       <= '0;
            illegal     <= 1'b0;
        end else if (s1_adv) begin
            out_valid   <= 1'b1;
            dst         <= alu_res;
            dst_sel_out <= s1_dst;
            flags       <= alu_flags;
            illegal     <= !s1_ctrl.legal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else if (s1_adv && s1_ctrl.opcode == OP_PCADD) begin
            pc_q <= alu_res;
        end
    end

    assign pc_out = pc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (DATA_W=20, NUM_REGS=16).
// Results are collected by a negedge monitor and compared in issue order.
// Expected values are hand-computed constants.
module tb_alu_pipe;

    localparam int DW = 20;
    localparam int NR = 16;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    opcode;
    logic [RW-1:0] src1_sel, src2_sel, dst_sel;
    logic [DW-1:0] src1_imm, src2_imm;
    logic          imm1_en, imm2_en, wb_en;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dst;
    logic [RW-1:0] dst_sel_out;
    logic [3:0]    flags;
    logic          illegal;
    logic [DW-1:0] pc_out;

    always #5 clk = ~clk;

    alu_pipe #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .src1_sel    (src1_sel),
        .src2_sel    (src2_sel),
        .dst_sel     (dst_sel),
        .src1_imm    (src1_imm),
        .src2_imm    (src2_imm),
        .imm1_en     (imm1_en),
        .imm2_en     (imm2_en),
        .wb_en       (wb_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dst         (dst),
        .dst_sel_out (dst_sel_out),
        .flags       (flags),
        .illegal     (illegal),
        .pc_out      (pc_out)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [3:0]    f;
        logic          il;
        logic [RW-1:0] sel;
    } res_t;

    res_t res_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready only changes just after a rising edge, so a handshake seen
    // here completes on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            res_q.push_back({dst, flags, illegal, dst_sel_out});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [RW-1:0] dsel, input logic wb,
                         input logic a_en, input logic [DW-1:0] a_imm, input logic [RW-1:0] a_sel,
                         input logic b_en, input logic [DW-1:0] b_imm, input logic [RW-1:0] b_sel);
        int n = 0;
        @(negedge clk);
        opcode   = op;   dst_sel  = dsel;  wb_en    = wb;
        imm1_en  = a_en; src1_imm = a_imm; src1_sel = a_sel;
        imm2_en  = b_en; src2_imm = b_imm; src2_sel = b_sel;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("issue_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            acc_cyc  = cyc;
        end
    endtask

    task automatic issue_ii(input logic [4:0] op, input logic [RW-1:0] dsel, input logic wb,
                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        issue(op, dsel, wb, 1'b1, a, '0, 1'b1, b, '0);
    endtask

    task automatic expect_res(input string tag, input logic [DW-1:0] e_d, input logic [3:0] e_f,
                              input logic e_il, input logic [RW-1:0] e_sel);
        int   n = 0;
        res_t r;
        while (res_q.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (res_q.size() == 0) begin
            chk({tag, "_timeout"}, 32'(res_q.size()), 32'd1);
        end else begin
            r = res_q.pop_front();
            chk({tag, "_dst"},   32'(r.d),   32'(e_d));
            chk({tag, "_flags"}, 32'(r.f),   32'(e_f));
            chk({tag, "_ill"},   32'(r.il),  32'(e_il));
            chk({tag, "_sel"},   32'(r.sel), 32'(e_sel));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int exp_gap;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; src1_sel = '0; src2_sel = '0; dst_sel = '0;
        src1_imm = '0; src2_imm = '0; imm1_en = 1'b0; imm2_en = 1'b0; wb_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),    32'd1);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_dst",       32'(dst),         32'd0);
        chk("rst_dst_sel",   32'(dst_sel_out), 32'd0);
        chk("rst_flags",     32'(flags),       32'd0);
        chk("rst_illegal",   32'(illegal),     32'd0);
        chk("rst_pc",        32'(pc_out),      32'd0);

        // MOV r1 <- 0x12345 ; ADD r2 = r1 + r1
        issue_ii(5'h0A, 4'd1, 1'b1, '0, 20'h12345);
        issue(5'h00, 4'd2, 1'b1, 1'b0, '0, 4'd1, 1'b0, '0, 4'd1);
        expect_res("mov_r1", 20'h12345, 4'h0, 1'b0, 4'd1);
        expect_res("add_r2", 20'h2468A, 4'h0, 1'b0, 4'd2);

        // Carry/zero and borrow/overflow/negative
        issue_ii(5'h00, 4'd0, 1'b0, 20'hFFFFF, 20'h00001);
        issue_ii(5'h01, 4'd0, 1'b0, 20'h7FFFF, 20'hFFFFF);
        expect_res("add_carry", 20'h00000, 4'h9, 1'b0, 4'd0);
        expect_res("sub_ovf",   20'h80000, 4'hE, 1'b0, 4'd0);

        // Back-to-back RAW: MOV r3 <- 5 ; ADD r4 = r3 + r3
        issue_ii(5'h0A, 4'd3, 1'b1, '0, 20'd5);
        t0 = acc_cyc;
        issue(5'h00, 4'd4, 1'b1, 1'b0, '0, 4'd3, 1'b0, '0, 4'd3);
`ifdef ALU_FWD_EN
        exp_gap = 1;
`else
        exp_gap = 2;
`endif
        chk("raw_gap_cycles", 32'(acc_cyc - t0), 32'(exp_gap));
        expect_res("raw_mov", 20'd5,  4'h0, 1'b0, 4'd3);
        expect_res("raw_add", 20'd10, 4'h0, 1'b0, 4'd4);

        // PCADD twice, back to back
        issue_ii(5'h09, 4'd0, 1'b0, '0, 20'h10);
        issue_ii(5'h09, 4'd0, 1'b0, '0, 20'h10);
        expect_res("pcadd1", 20'h10, 4'h0, 1'b0, 4'd0);
        expect_res("pcadd2", 20'h20, 4'h0, 1'b0, 4'd0);
        chk("pc_after", 32'(pc_out), 32'h20);

        // Shifts and SLT
        issue_ii(5'h07, 4'd0, 1'b0, 20'h80000, 20'd25);
        issue_ii(5'h05, 4'd0, 1'b0, 20'h00001, 20'd19);
        issue_ii(5'h08, 4'd0, 1'b0, 20'hFFFFF, 20'd1);
        expect_res("sra_big", 20'hFFFFF, 4'h2, 1'b0, 4'd0);
        expect_res("sll_19",  20'h80000, 4'h2, 1'b0, 4'd0);
        expect_res("slt_neg", 20'h00001, 4'h0, 1'b0, 4'd0);

        // Illegal op must not write its destination
        issue_ii(5'h0A, 4'd5, 1'b1, '0, 20'h0ABCD);
        issue_ii(5'h1F, 4'd5, 1'b1, 20'd3, 20'd4);
        issue(5'h0A, 4'd6, 1'b0, 1'b1, '0, '0, 1'b0, '0, 4'd5);
        expect_res("ill_pre",  20'h0ABCD, 4'h0, 1'b0, 4'd5);
        expect_res("ill_op",   20'h00000, 4'h0, 1'b1, 4'd5);
        expect_res("ill_read", 20'h0ABCD, 4'h0, 1'b0, 4'd6);

        // Backpressure: out_ready low for 4 cycles while 3 ops are issued
        @(posedge clk);
        #1 out_ready = 1'b0;
        fork
            begin
                issue_ii(5'h0A, 4'd6, 1'b1, '0, 20'h111);
                issue_ii(5'h0A, 4'd7, 1'b1, '0, 20'h222);
                @(negedge clk);
                #1;
                chk("bp_ready_drop", 32'(in_ready), 32'd0);
                issue_ii(5'h00, 4'd0, 1'b0, 20'h300, 20'h33);
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_dst",   32'(dst),       32'h111);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        expect_res("bp_1", 20'h111, 4'h0, 1'b0, 4'd6);
        expect_res("bp_2", 20'h222, 4'h0, 1'b0, 4'd7);
        expect_res("bp_3", 20'h333, 4'h0, 1'b0, 4'd0);

        // Reset with an op sitting in S1: nothing is written back
        issue_ii(5'h0A, 4'd8, 1'b1, '0, 20'h55);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_pc",    32'(pc_out),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        res_q.delete();
        issue(5'h0A, 4'd9, 1'b0, 1'b1, '0, '0, 1'b0, '0, 4'd8);
        expect_res("mid_rst_r8", 20'h0, 4'h1, 1'b0, 4'd9);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
